// File: rtl/instr_fetch_controller.sv
// Instruction fetch sequencer: drives the PC into an async-read instruction memory,
// buffers returned words in a small prefetch queue and hands them to decode via valid/ready.
module instr_fetch_controller #(
  parameter int unsigned   N         = 32,
  parameter int unsigned   M         = 1024,
  parameter int unsigned   DEPTH     = 2,
  parameter int unsigned   RESET_PC  = 0,
  parameter logic [N-1:0]  HALT_WORD = N'(32'hFFFF_FFFF)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic [N-1:0] imem_address,
  input  logic [N-1:0] imem_data,
  output logic         instr_valid,
  input  logic         instr_ready,
  output logic [N-1:0] instr_data,
  output logic [N-1:0] instr_pc,
  input  logic         redirect_valid,
  input  logic [N-1:0] redirect_pc,
  output logic         halted
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_HALTED  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [N-1:0]       pc_q, pc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [N-1:0]       q_data_q [DEPTH];
  logic [N-1:0]       q_data_d [DEPTH];
  logic [N-1:0]       q_pc_q   [DEPTH];
  logic [N-1:0]       q_pc_d   [DEPTH];

  logic pop_c;
  logic push_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Redirect suppresses both queue ports; a full queue may still push if the head leaves.
  assign pop_c  = (cnt_q != '0) && instr_ready && !redirect_valid;
  assign push_c = (state_q == S_FETCH) && (pc_q < N'(M)) && !redirect_valid &&
                  ((cnt_q < CNT_W'(DEPTH)) || pop_c);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    q_data_d = q_data_q;
    q_pc_d   = q_pc_q;

    if (redirect_valid) begin
      cnt_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      pc_d     = redirect_pc;
      if (state_q != S_IDLE) begin
        state_d = (redirect_pc < N'(M)) ? S_FETCH : S_HALTED;
      end
    end else begin
      if ((state_q == S_IDLE) && start) begin
        state_d = S_FETCH;
      end

      if (push_c) begin
        q_data_d[wr_ptr_q] = imem_data;
        q_pc_d[wr_ptr_q]   = pc_q;
        wr_ptr_d           = ptr_inc(wr_ptr_q);
        pc_d               = pc_q + N'(1);
        // The halt word is still enqueued so decode sees it.
        if ((imem_data == HALT_WORD) || (pc_q == N'(M - 1))) begin
          state_d = S_HALTED;
        end
      end

      if (pop_c) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end

      case ({push_c, pop_c})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      pc_q     <= N'(RESET_PC);
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        q_data_q[i] <= '0;
        q_pc_q[i]   <= '0;
      end
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      q_data_q <= q_data_d;
      q_pc_q   <= q_pc_d;
    end
  end

  // Head outputs come straight from queue storage, forced to zero when empty.
  assign imem_address = pc_q;
  assign instr_valid  = (cnt_q != '0);
  assign instr_data   = instr_valid ? q_data_q[rd_ptr_q] : '0;
  assign instr_pc     = instr_valid ? q_pc_q[rd_ptr_q]   : '0;
  assign halted       = (state_q == S_HALTED) && (cnt_q == '0);

endmodule

// File: doc/instr_fetch_controller.md
Name: instr_fetch_controller

Overview:
- Sequences the asynchronous-read, word-indexed instruction memory for the hybrid ARM/MIPS core.
- Holds the fetch PC and drives the memory address each cycle.
- Captures returned words into a small prefetch queue and presents them to decode through a valid/ready handshake.
- Handles branch redirects (queue flush), halt-word detection and end-of-memory stop.

Parameters:
- N, 32, data and address width in bits.
- M, 1024, instruction memory depth in words; valid PCs are 0..M-1.
- DEPTH, 2, prefetch queue entries; must be 2 or greater.
- RESET_PC, 0, PC loaded at reset (word index).
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that stops fetching.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-low reset.
- start  input  1  begin fetching from the current PC (sampled in IDLE only).
- imem_address  output  N  word index to instruction memory; combinational, equals pc.
- imem_data  input  N  word returned combinationally by memory for imem_address.
- instr_valid  output  1  head of queue holds a valid instruction.
- instr_ready  input  1  decode accepts the head this cycle.
- instr_data  output  N  instruction word at head.
- instr_pc  output  N  word index the head was fetched from.
- redirect_valid  input  1  branch/exception redirect request.
- redirect_pc  input  N  new fetch PC (word index).
- halted  output  1  fetch stopped and queue drained.

Behaviour:
- Reset (rst=0 at an edge):
  - State=IDLE, pc=RESET_PC, queue count=0, pointers=0.
  - instr_valid=0, instr_data=0, instr_pc=0, halted=0.
  - Reset overrides every input, including mid-fetch and mid-redirect.
- States and transitions:
  - IDLE: no fetch. start=1 -> FETCH. Redirect in IDLE loads pc and stays IDLE.
  - FETCH: push on a cycle when no redirect and (count<DEPTH or pop occurs this cycle).
    - Pushed entry is {pc, imem_data}; pc<=pc+1.
    - If the pushed word equals HALT_WORD, or pc==M-1, go to HALTED. The halt word itself is enqueued. pc does not wrap; it stays at the last fetched index +1, saturated at M.
  - HALTED: no fetch. halted=1 when count==0 (combinational from registered count).
- Pop: occurs when instr_valid=1 and instr_ready=1; the head is removed at the edge.
  - Simultaneous push and pop when full is legal; count unchanged.
- Outputs:
  - instr_valid = (count!=0).
  - instr_data/instr_pc are driven from registered queue storage at the read pointer, and are 0 when empty.
- Redirect has highest priority over push, pop and start:
  - Queue is flushed (count=0, pointers=0) and pc<=redirect_pc.
  - No push occurs that cycle, and instr_ready is ignored.
  - From FETCH or HALTED: redirect_pc<M -> FETCH, otherwise HALTED.
  - instr_valid=0 in the cycle after a redirect.
- Latency:
  - start at edge t -> FETCH.
  - First push at edge t+1; instr_valid=1 after t+1.
  - Redirect at edge r -> first new instruction valid after r+1.
- Steady state: one instruction per cycle when decode holds instr_ready=1.
- Out-of-range: imem_address equals pc even when pc>=M, but no fetch is performed there.

Test Plan:
- Reset then start=1, ready=1, memory words 0..3 = A,B,C,D -> instr_valid rises 2 edges after start; outputs (pc,data) (0,A),(1,B),(2,C),(3,D) on consecutive cycles.
- ready=0 for 5 cycles after start -> count saturates at 2 with heads (0,A) then (1,B), pc stops at 2. Releasing ready delivers A,B,C with no loss or duplication.
- Redirect to 40 while queue holds 2 entries and ready=1 -> next cycle instr_valid=0; then (40,mem[40]) valid; flushed entries never appear.
- mem[5]=32'hFFFF_FFFF -> entries 0..5 delivered including the halt word; imem_address freezes at 6; halted=1 after the last pop. Redirect to 0 resumes fetching.
- RESET_PC=M-2 -> fetches M-2 and M-1, enters HALTED without wrap; redirect_pc=M keeps HALTED with an empty queue.
- rst=0 asserted mid-stream with full queue and redirect_valid=1 -> next cycle all outputs at reset values, state IDLE, pc=RESET_PC.
